// File: rtl/cacheline_mem_arbiter.sv
// Shares the single 256-bit cacheline memory port between the I-side prefetcher
// and the D-cache miss/writeback port: D priority with an I starvation guard.
module cacheline_mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_address,
  input  logic             i_read,
  output logic [255:0]     i_rdata256,
  output logic             i_resp,
  input  logic [31:0]      d_address,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [255:0]     d_wdata256,
  output logic [255:0]     d_rdata256,
  output logic             d_resp,
  output logic [31:0]      mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [255:0]     mem_wdata256,
  input  logic [255:0]     mem_rdata256,
  input  logic             mem_resp,
  output logic             arbiter_idle,
  output logic [CNT_W-1:0] i_grant_count,
  output logic [CNT_W-1:0] d_grant_count
);

  // state   | meaning
  // IDLE    | port free, choosing the next requester
  // SERVE_I | I-side read outstanding on memory
  // SERVE_D | D-side read or write outstanding on memory
  // DONE    | dead cycle so the served requester can drop its request
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0]       STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [255:0]     wdata_q, wdata_d;
  logic             op_q, op_d;
  logic [3:0]       streak_q, streak_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic             d_req, grant_i, grant_d;

  // I wins only when D is silent or D has used up its streak allowance.
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = i_read & (~d_req | (streak_q == STREAK_MAX));
    grant_d = d_req & ~grant_i;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    streak_d     = streak_q;
    i_cnt_d      = i_cnt_q;
    d_cnt_d      = d_cnt_q;
    mem_address  = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata256 = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata256   = '0;
    d_rdata256   = '0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = SERVE_I;
          addr_d   = {i_address[31:5], 5'b0};
          op_d     = 1'b0;
          streak_d = '0;
        end else if (grant_d) begin
          state_d  = SERVE_D;
          addr_d   = {d_address[31:5], 5'b0};
          wdata_d  = d_wdata256;
          op_d     = d_write;
          if (!i_read)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
        end
      end
      SERVE_I: begin
        mem_address = addr_q;
        mem_read    = 1'b1;
        if (mem_resp) begin
          i_resp     = 1'b1;
          i_rdata256 = mem_rdata256;
          state_d    = DONE;
          if (i_cnt_q != CNT_MAX)
            i_cnt_d = i_cnt_q + 1'b1;
        end
      end
      SERVE_D: begin
        mem_address  = addr_q;
        mem_read     = ~op_q;
        mem_write    = op_q;
        mem_wdata256 = wdata_q;
        if (mem_resp) begin
          d_resp     = 1'b1;
          d_rdata256 = mem_rdata256;
          state_d    = DONE;
          if (d_cnt_q != CNT_MAX)
            d_cnt_d = d_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arbiter_idle  = (state_q == IDLE) & ~i_read & ~d_read & ~d_write;
    i_grant_count = i_cnt_q;
    d_grant_count = d_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= 1'b0;
      streak_q <= '0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      streak_q <= streak_d;
      i_cnt_q  <= i_cnt_d;
      d_cnt_q  <= d_cnt_d;
    end
  end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: vector table, directed corner sequences and
// randomized transactions against a transaction-level arbitration model.
module tb_cacheline_mem_arbiter;
  localparam int LIMIT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address, d_address, mem_address;
  logic         i_read, d_read, d_write;
  logic [255:0] d_wdata256, mem_rdata256, i_rdata256, d_rdata256, mem_wdata256;
  logic         mem_resp, i_resp, d_resp, mem_read, mem_write, arbiter_idle;
  logic [15:0]  i_grant_count, d_grant_count;

  logic [31:0]  mem_address2;
  logic         i_resp2, d_resp2, mem_read2, mem_write2, arbiter_idle2;
  logic [255:0] i_rdata2, d_rdata2, mem_wdata2;
  logic [1:0]   i_grant_count2, d_grant_count2;

  cacheline_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata256(i_rdata256), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata256(d_wdata256),
    .d_rdata256(d_rdata256), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .arbiter_idle(arbiter_idle), .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  // Narrow-counter copy sharing all inputs, used for counter saturation.
  cacheline_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata256(i_rdata2), .i_resp(i_resp2),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata256(d_wdata256),
    .d_rdata256(d_rdata2), .d_resp(d_resp2),
    .mem_address(mem_address2), .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_wdata256(mem_wdata2), .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .arbiter_idle(arbiter_idle2), .i_grant_count(i_grant_count2), .d_grant_count(d_grant_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ir, dr, dw;
    logic [31:0]  ia, da;
    logic [255:0] wd;
    int           lat;
    logic         exp_i, exp_w;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[14];
  int n_tests = 0, n_fail = 0;
  int m_streak = 0, m_cnt_i = 0, m_cnt_d = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_icnt"}, 256'(i_grant_count), 256'(sat(m_cnt_i, 65535)));
    check({tag, "_dcnt"}, 256'(d_grant_count), 256'(sat(m_cnt_d, 65535)));
    check({tag, "_icnt_w2"}, 256'(i_grant_count2), 256'(sat(m_cnt_i, 3)));
    check({tag, "_dcnt_w2"}, 256'(d_grant_count2), 256'(sat(m_cnt_d, 3)));
  endtask

  // Called at posedge+1 with the arbiter in IDLE; returns at posedge+1 of the next IDLE.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd,
                         input int lat, input logic exp_i, input logic exp_w,
                         input logic [31:0] exp_addr, input string tag);
    logic [255:0] rd;
    i_read = ir; d_read = dr; d_write = dw;
    i_address = ia; d_address = da; d_wdata256 = wd;
    #1;
    check({tag, "_idle_req"}, 256'(arbiter_idle), 256'(!(ir | dr | dw)));
    @(posedge clk); #1;
    i_address = $urandom; d_address = $urandom; d_wdata256 = rand256();
    rd = rand256();
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        mem_rdata256 = rd;
        mem_resp = 1'b1;
      end
      #1;
      check({tag, "_mem_read"}, 256'(mem_read), 256'(!exp_w));
      check({tag, "_mem_write"}, 256'(mem_write), 256'(exp_w));
      check({tag, "_mem_addr"}, 256'(mem_address), 256'(exp_addr));
      if (!exp_i) check({tag, "_mem_wdata"}, mem_wdata256, wd);
      if (c == lat) begin
        check({tag, "_i_resp"}, 256'(i_resp), 256'(exp_i));
        check({tag, "_d_resp"}, 256'(d_resp), 256'(!exp_i));
        check({tag, "_i_rdata"}, i_rdata256, exp_i ? rd : 256'd0);
        check({tag, "_d_rdata"}, d_rdata256, exp_i ? 256'd0 : rd);
      end else begin
        check({tag, "_no_resp"}, 256'({i_resp, d_resp}), 256'd0);
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if (exp_i) begin
      m_cnt_i++;
      m_streak = 0;
    end else begin
      m_cnt_d++;
      m_streak = ir ? sat(m_streak + 1, LIMIT) : 0;
    end
    #1;
    check({tag, "_done_quiet"}, 256'({mem_read, mem_write, arbiter_idle}), 256'd0);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 256'(arbiter_idle), 256'd1);
    check({tag, "_w2_idle"}, 256'(|{mem_address2, mem_read2, mem_write2, mem_wdata2,
                                    i_resp2, d_resp2, i_rdata2, d_rdata2, ~arbiter_idle2}), 256'd0);
    check_counts(tag);
  endtask

  initial begin
    logic [7:0]  got_order, exp_order;
    int          got, cyc;
    logic        ir, dr, dw, ei, ew;
    logic [31:0] ia, da;

    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata256 = '0; mem_rdata256 = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, rand256(), 1, 1'b1, 1'b0, 32'h0000_1220};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, {8{32'h1234_5678}}, 10, 1'b0, 1'b1, 32'h8000_0040};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_007F, rand256(), 0, 1'b0, 1'b1, 32'h0000_0060};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'hAAAA_AAB0, 32'h5555_5551, rand256(), 2, 1'b0, 1'b0, 32'h5555_5540};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'hAAAA_AAB0, 32'h1000_001F, rand256(), 0, 1'b0, 1'b1, 32'h1000_0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'hAAAA_AAB0, 32'h2000_0020, rand256(), 1, 1'b0, 1'b0, 32'h2000_0020};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h3000_003F, 32'h2000_0020, rand256(), 0, 1'b1, 1'b0, 32'h3000_0020};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0004, rand256(), 0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, rand256(), 0, 1'b0, 1'b0, 32'h0000_0200};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0300, rand256(), 0, 1'b0, 1'b0, 32'h0000_0300};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, rand256(), 0, 1'b0, 1'b0, 32'h0000_0200};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, rand256(), 1, 1'b0, 1'b0, 32'h0000_0200};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, rand256(), 0, 1'b0, 1'b0, 32'h0000_0200};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, rand256(), 3, 1'b1, 1'b0, 32'h0000_0100};

    #1;
    check("rst_mem", 256'({mem_read, mem_write, mem_address, i_resp, d_resp}), 256'd0);
    check("rst_wdata", mem_wdata256, 256'd0);
    check("rst_idle", 256'(arbiter_idle), 256'd1);
    check_counts("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int v = 0; v < 14; v++)
      run_txn(vecs[v].ir, vecs[v].dr, vecs[v].dw, vecs[v].ia, vecs[v].da, vecs[v].wd,
              vecs[v].lat, vecs[v].exp_i, vecs[v].exp_w, vecs[v].exp_addr, $sformatf("vec%0d", v));

    // Asynchronous reset in the middle of a D write.
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata256 = rand256();
    @(posedge clk); #1;
    check("arst_pre_write", 256'(mem_write), 256'd1);
    #3 rst = 1'b0;
    #1;
    check("arst_write_drop", 256'({mem_write, mem_read}), 256'd0);
    m_cnt_i = 0; m_cnt_d = 0; m_streak = 0;
    check_counts("arst");
    d_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rdata256 = rand256(); mem_resp = 1'b1;
    #1;
    check("arst_late_resp", 256'({i_resp, d_resp, i_rdata256 != 0, d_rdata256 != 0}), 256'd0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    #1;
    check("arst_idle", 256'(arbiter_idle), 256'd1);
    check_counts("arst_after");

    // Both sides held continuously against a single-cycle memory.
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h0000_0100; d_address = 32'h0000_0200;
    got = 0; cyc = 0; got_order = '0; exp_order = 8'b1000_1000;
    while (got < 8 && cyc < 100) begin
      @(posedge clk); #1;
      mem_resp = 1'b0;
      #1;
      if (mem_read) begin
        got_order[got] = (mem_address == 32'h0000_0100);
        mem_resp = 1'b1;
        got++;
      end
      cyc++;
    end
    check("starve_grants_seen", 256'(got), 256'd8);
    check("starve_order", 256'(got_order), 256'(exp_order));
    @(posedge clk); #1;
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    @(posedge clk); #1;
    m_cnt_i += 2; m_cnt_d += 6; m_streak = 0;
    check("starve_idle", 256'(arbiter_idle), 256'd1);
    check_counts("starve");

    // Responses arriving with no grant outstanding.
    for (int k = 0; k < 3; k++) begin
      mem_rdata256 = rand256(); mem_resp = 1'b1;
      #1;
      check("idle_resp", 256'({i_resp, d_resp, mem_read, mem_write}), 256'd0);
      @(posedge clk); #1;
      mem_resp = 1'b0;
    end
    check_counts("idle_resp");

    for (int t = 0; t < 40; t++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!(ir | dr | dw)) ir = 1'b1;
      ia = $urandom; da = $urandom;
      ei = ir && (!(dr || dw) || m_streak == LIMIT);
      ew = !ei && dw;
      run_txn(ir, dr, dw, ia, da, rand256(), int'($urandom_range(0, 3)), ei, ew,
              (ei ? ia : da) & 32'hFFFF_FFE0, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Shares the single 256-bit cacheline memory port between the instruction side and the data side.
- The instruction side is the next-line prefetcher's downstream port; the data side is the D-cache miss/writeback port.
- Grants one requester at a time, holds the grant until memory responds, and uses D-priority with a starvation guard for the I side.
- Exports arbiter_idle so the prefetcher issues speculative fills only while the memory port is free.

Parameters:
STARVE_LIMIT, 3, consecutive D grants allowed while an I request is pending before I is forced next (1..15)
CNT_W, 16, width of the saturating grant counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
i_address  input  32  I-side cacheline address
i_read  input  1  I-side read request, level, held until i_resp
i_rdata256  output  256  I-side read data, valid when i_resp=1
i_resp  output  1  I-side completion pulse
d_address  input  32  D-side cacheline address
d_read  input  1  D-side read request, level
d_write  input  1  D-side write request, level
d_wdata256  input  256  D-side write data
d_rdata256  output  256  D-side read data, valid when d_resp=1
d_resp  output  1  D-side completion pulse
mem_address  output  32  memory address, low 5 bits forced 0
mem_read  output  1  memory read
mem_write  output  1  memory write
mem_wdata256  output  256  memory write data
mem_rdata256  input  256  memory read data
mem_resp  input  1  memory completion, one cycle
arbiter_idle  output  1  port free and no request pending
i_grant_count  output  CNT_W  saturating count of completed I transactions
d_grant_count  output  CNT_W  saturating count of completed D transactions

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; address/data/op registers, streak counter and both grant counters clear to 0.
  - All mem_* outputs, i_resp and d_resp are 0; arbiter_idle is 1.
  - rst asserted mid-transaction drops mem_read/mem_write in the same cycle. Any later mem_resp is ignored.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE grant selection, registered at the clock edge:
  - d_req = d_read|d_write.
  - If d_req and i_read are both high: grant I if streak==STARVE_LIMIT, else grant D.
  - Only one side requesting: grant that side.
  - Neither requesting: stay in IDLE.
- On grant:
  - Latch the granted side's address into addr_q with bits [4:0] forced to 0.
  - For D, also latch d_wdata256 and op_q. op_q is write if d_write=1, else read; write wins if both are high.
- SERVE_x outputs:
  - mem_address=addr_q; mem_read or mem_write per op_q (I is always read); mem_wdata256 = latched data.
  - Outputs stay stable for the whole transaction, independent of requester inputs after the grant.
- Response path:
  - mem_resp is forwarded combinationally to the granted side's *_resp in the same cycle, with *_rdata256 = mem_rdata256.
  - The non-granted resp is 0. *_rdata256 is 0 when its resp is 0.
- On mem_resp in SERVE_x: go to DONE and increment that side's grant counter, saturating at all-ones.
- DONE: one dead cycle, no mem_* asserted and no grant, so the requester can drop its request. Then go to IDLE.
- Latency:
  - Request high in IDLE at cycle N gives mem_* asserted at N+1.
  - mem_resp at cycle M gives *_resp at M, DONE at M+1, IDLE at M+2.
  - Earliest next mem_* is M+3.
- Streak counter:
  - On a D grant while i_read=1: streak+1, saturating at STARVE_LIMIT.
  - On any I grant: streak=0.
  - On a D grant while i_read=0: streak=0.
- arbiter_idle = (state==IDLE) & ~i_read & ~d_read & ~d_write. Combinational, and 0 in SERVE_x and DONE.
- mem_resp in IDLE or DONE is ignored: no resp, no counter change.
- Requests deasserted before a response are a protocol violation. The arbiter still completes the transaction and discards the resp.

Test Plan:
- Reset, then i_read=1, i_address=0x0000_1234 with d idle:
  - next cycle mem_read=1, mem_address=0x0000_1220.
  - mem_resp with rdata=0xA5.. gives i_resp=1, i_rdata256=0xA5.. the same cycle.
  - i_grant_count=1; arbiter_idle=1 two cycles later.
- D write, d_address=0x8000_0040, d_wdata256=0x1234..:
  - mem_write=1, mem_read=0, mem_wdata256 held across a 10-cycle response delay.
  - d_resp=1 on mem_resp; d_grant_count=1.
- i_read and d_read held continuously with STARVE_LIMIT=3, 1-cycle memory:
  - grant order D,D,D,I,D,D,D,I.
  - streak returns to 0 after each I grant.
- Simultaneous d_read=1 and d_write=1: mem_write=1 only.
- Assert rst=0 asynchronously between edges during SERVE_D:
  - mem_write drops to 0 immediately; counters read 0.
  - A later mem_resp produces no d_resp.
- mem_resp pulsed while IDLE: i_resp=d_resp=0, counters unchanged.
- CNT_W=2 with 5 I transactions: i_grant_count saturates at 3.
